// File: rtl/seq_cla_pkg.sv
// Shared types and sizing helpers for the nibble-serial carry-lookahead adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_cla_pkg;

    // Width of the single lookahead slice that is reused every cycle.
    localparam int NIB_W = 4;

    // Controller states: waiting for a request, or stepping through nibbles.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Completion flags captured together with the result.
    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

    // Number of slice iterations needed for a WIDTH-bit operation.
    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int idx_width(input int width);
        int nib;
        nib = nib_count(width);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/seq_cla_adder_slice4.sv
// 4-bit carry-lookahead slice: sum nibble plus carries into and out of bit 3.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module cla_slice4
    import seq_cla_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             c3,
    output logic             c4
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is flattened from generate/propagate terms so that the
    // slice depth stays at one lookahead level instead of a ripple chain.
    always_comb begin
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
    end

    assign s  = p ^ c;
    assign c3 = c[3];

endmodule

// File: rtl/seq_cla_adder.sv
// Nibble-serial WIDTH-bit add/subtract built around one 4-bit lookahead slice.
// Latency: done pulses WIDTH/4 edges after the accept edge; one op per WIDTH/4+1 cycles.
// Backpressure: start is taken only while busy=0; starts during busy are dropped, not queued.
module seq_cla_adder
    import seq_cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    // The nibble sequencing only works for whole nibbles and at least two steps.
    generate
        if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_width_check
            $error("seq_cla_adder: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_t             state_q;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_nxt;
    logic               carry_q;
    logic [WIDTH-1:0]   result_q;
    flags_t             flags_q;
    logic               done_q;

    logic               accept;
    logic               last_nib;
    logic [NIB_W-1:0]   slice_a;
    logic [NIB_W-1:0]   slice_b;
    logic [NIB_W-1:0]   slice_s;
    logic               slice_c3;
    logic               slice_c4;

    assign accept   = (state_q == IDLE) && start;
    assign last_nib = (state_q == RUN) && (idx_q == LAST_IDX);

    // Current nibble of each operand; B is already inverted for subtraction.
    assign slice_a = opa_q[idx_q * NIB_W +: NIB_W];
    assign slice_b = opb_q[idx_q * NIB_W +: NIB_W];

    cla_slice4 u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_q),
        .s   (slice_s),
        .c3  (slice_c3),
        .c4  (slice_c4)
    );

    // Accumulator image with this cycle's sum nibble merged in; on the last
    // nibble this is the complete result, so zero is judged on it directly.
    always_comb begin
        acc_nxt = acc_q;
        acc_nxt[idx_q * NIB_W +: NIB_W] = slice_s;
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state: leave IDLE on a request, return after the last nibble.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture at accept, then one nibble of accumulation per RUN cycle.
    // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
    always_ff @(posedge clk) begin
        if (reset) begin
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= sub;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            acc_q   <= acc_nxt;
            carry_q <= slice_c4;
            idx_q   <= idx_q + 1'b1;
        end
    end

    // Visible result and flags change only at completion; done is a one-cycle echo.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= last_nib;
            if (last_nib) begin
                result_q      <= acc_nxt;
                flags_q.cout  <= slice_c4;
                flags_q.ovf   <= slice_c3 ^ slice_c4;
                flags_q.zero  <= (acc_nxt == '0);
            end
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign result = result_q;
    assign cout   = flags_q.cout;
    assign ovf    = flags_q.ovf;
    assign zero   = flags_q.zero;

endmodule

// File: tb/tb_seq_cla_adder.sv
// Self-checking bench for seq_cla_adder against an arithmetic reference model.
// Latency: checks done arrives WIDTH/4 edges after accept.
// Backpressure: exercises starts ignored while busy and starts taken in the done cycle.
module tb_seq_cla_adder;

    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_cla_adder #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero)
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arithmetic on whole words plus a countdown to completion.
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_result = '0;
    logic             m_cout = 1'b0;
    logic             m_ovf = 1'b0;
    logic             m_zero = 1'b0;
    int               m_left = 0;
    logic [WIDTH-1:0] p_result;
    logic             p_cout;
    logic             p_ovf;
    logic [WIDTH-1:0] p_bb;
    logic [WIDTH:0]   p_sum;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_left = 0;
            m_result = '0; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy   = 1'b0;
                    m_done   = 1'b1;
                    m_result = p_result;
                    m_cout   = p_cout;
                    m_ovf    = p_ovf;
                    m_zero   = (p_result == '0);
                end
            end else if (start) begin
                p_bb     = sub ? ~b : b;
                p_sum    = {1'b0, a} + {1'b0, p_bb} + {{WIDTH{1'b0}}, sub};
                p_result = p_sum[WIDTH-1:0];
                p_cout   = p_sum[WIDTH];
                p_ovf    = (a[WIDTH-1] == p_bb[WIDTH-1]) && (p_result[WIDTH-1] != a[WIDTH-1]);
                m_busy   = 1'b1;
                m_left   = NIB;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("cyc_busy",   busy,   m_busy);
            cmp("cyc_done",   done,   m_done);
            cmp("cyc_result", result, m_result);
            cmp("cyc_cout",   cout,   m_cout);
            cmp("cyc_ovf",    ovf,    m_ovf);
            cmp("cyc_zero",   zero,   m_zero);
        end
    end

    // Hand-computed expectations applied to both the DUT and the model.
    task automatic expect_out(input string tag, input logic [WIDTH-1:0] r,
                              input logic c, input logic o, input logic z);
        cmp({tag, "_result"}, result, r);
        cmp({tag, "_cout"},   cout,   c);
        cmp({tag, "_ovf"},    ovf,    o);
        cmp({tag, "_zero"},   zero,   z);
        cmp({tag, "_model_result"}, m_result, r);
        cmp({tag, "_model_flags"},  {m_cout, m_ovf, m_zero}, {c, o, z});
    endtask

    // Present a request for exactly the accept edge, then scramble the operands.
    task automatic accept_op(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        start = 1'b1; sub = s; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
    endtask

    // Wait (bounded) for done; optionally pulse a 9+9 start on RUN cycle 'poke'.
    task automatic wait_done(input string name, input int poke);
        int lat;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = (k == poke);
            if (k == poke) begin
                a = 32'd9; b = 32'd9; sub = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        cmp(name, lat, NIB);
    endtask

    logic [WIDTH-1:0] corners [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        // Reset held two cycles with start asserted: nothing may be accepted.
        reset = 1'b1; start = 1'b1; sub = 1'b0; a = 32'd1; b = 32'd2;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        cmp("rst_busy", busy, 1'b0);
        cmp("rst_done", done, 1'b0);
        expect_out("rst", 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        cmp("rst_no_accept", busy, 1'b0);

        accept_op(1'b0, 32'h0000_0001, 32'hFFFF_FFFF);
        wait_done("lat_add_wrap", 0);
        expect_out("add_wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        accept_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
        wait_done("lat_add_ovf", 0);
        expect_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        accept_op(1'b1, 32'h8000_0000, 32'h0000_0001);
        wait_done("lat_sub_ovf", 0);
        expect_out("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        accept_op(1'b1, 32'd5, 32'd7);
        wait_done("lat_sub_borrow", 0);
        expect_out("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        // Start during RUN is dropped; start in the done cycle is taken.
        accept_op(1'b0, 32'd1, 32'd2);
        wait_done("lat_ignore", 3);
        expect_out("ignore", 32'd3, 1'b0, 1'b0, 1'b0);
        cmp("done_cycle_idle", busy, 1'b0);
        accept_op(1'b1, 32'd4, 32'd1);
        wait_done("lat_b2b", 0);
        expect_out("b2b", 32'd3, 1'b1, 1'b0, 1'b0);

        // Reset on the 4th RUN cycle discards the operation.
        accept_op(1'b0, 32'h1234_5678, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        cmp("mid_rst_busy", busy, 1'b0);
        cmp("mid_rst_done", done, 1'b0);
        expect_out("mid_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            cmp("mid_rst_no_done", done, 1'b0);
        end
        accept_op(1'b0, 32'd2, 32'd2);
        wait_done("lat_after_rst", 0);
        expect_out("after_rst", 32'd4, 1'b0, 1'b0, 1'b0);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 32'($urandom);
            accept_op(1'($urandom_range(0, 1)), ra, rb);
            wait_done("lat_rand", $urandom_range(0, 7));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/seq_cla_adder.md
# seq_cla_adder

Multi-cycle WIDTH-bit adder/subtractor that reuses a single 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first. It sits in the execute path as the area-reduced alternative to a full-width combinational adder. It takes operands from the datapath through a start/busy/done handshake and returns the sum plus flags to writeback and the branch comparator.

## Interface
- WIDTH, 32, operand/result width; multiple of 4, minimum 8; NIB = WIDTH/4 slice iterations
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; only clk and reset are shared, no other clock or async reset
- start  in  1  request; accepted only on an edge where busy=0
- sub  in  1  0 = a+b, 1 = a-b (a + ~b + 1); sampled at accept
- a  in  WIDTH  operand A; sampled at accept only
- b  in  WIDTH  operand B; sampled at accept only
- busy  out  1  high while iterating; reset 0
- done  out  1  one-cycle completion pulse; reset 0
- result  out  WIDTH  sum/difference; reset 0
- cout  out  1  carry out of MSB; for sub, 1 = no borrow (a >= b unsigned); reset 0
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB; reset 0
- zero  out  1  result == 0; reset 0

## Operation
- States: IDLE, RUN.
- IDLE with start=1 at an edge:
  - latch a into opa and (sub ? ~b : b) into opb
  - carry register <= sub
  - nibble index <= 0
  - go to RUN, busy=1
- RUN, each edge:
  - slice sums opa[idx], opb[idx] and the carry register
  - the sum nibble is written into the internal accumulator at position idx
  - carry register <= slice c4
  - idx++
- Edge with idx = NIB-1:
  - go to IDLE
  - copy accumulator to result; set cout = slice c4, ovf = slice c3 ^ c4, zero = (full sum == 0)
  - done=1 for exactly the following cycle
- result, cout, ovf and zero change only at the completion edge or at reset. They hold their value through later operations until the next completion.
- start while busy=1 is ignored; it is not queued.
- start in the done cycle is accepted, because busy=0 then. Back-to-back throughput is one operation per NIB+1 cycles.
- Slice function: standard 4-bit carry lookahead.
  - gi = ai & bi, pi = ai ^ bi
  - ci+1 = gi | pi & ci
  - si = pi ^ ci
  - the slice exports c3 (carry into bit 3) and c4
- Reset mid-RUN: next cycle is IDLE; busy, done and all outputs are 0; the in-flight operation is discarded with no done.

## Timing
- Accept edge E0. RUN occupies the cycles after E0 through E(NIB). done is high in the cycle after E(NIB); for WIDTH=32 that is 8 edges after accept.
- busy rises the cycle after E0 and falls in the same cycle done rises.
- Outputs are registered. The only combinational path is slice logic between operand/carry registers and the accumulator; the critical path is one 4-bit lookahead.
- Operands may change freely after the accept edge.

## Structure
- Package seq_cla_pkg holds:
  - the state enum typedef (IDLE, RUN)
  - localparam NIB_W = 4
  - a function computing NIB from WIDTH for the index counter width, $clog2(NIB)
- Sub-module cla_slice4 is combinational: inputs a[3:0], b[3:0], cin; outputs s[3:0], c3, c4.
- Top module: FSM, index counter, operand/accumulator/carry registers, output flag registers. The top has a WIDTH%4==0 and WIDTH>=8 elaboration assertion.

## Test plan
- Reset: hold reset for 2 cycles with start=1. Required: busy=0, done=0, result=0, all flags 0, and no accept occurs.
- add 0x0000_0001 + 0xFFFF_FFFF. Required: done exactly 8 edges after accept; result 0x0000_0000, cout=1, zero=1, ovf=0.
- add 0x7FFF_FFFF + 0x0000_0001. Required: result 0x8000_0000, ovf=1, cout=0, zero=0.
- Subtraction cases, required response for each:
  - sub 0x8000_0000 - 0x0000_0001 gives 0x7FFF_FFFF, ovf=1, cout=1
  - sub 5 - 7 gives 0xFFFF_FFFE, cout=0, ovf=0
- start with 1+2 accepted, then start with 9+9 pulsed mid-RUN. Required: the second start is ignored and the first returns result 3. A third start in the done cycle (4-1) is accepted and returns 3 after 8 more edges.
- Start 0x1234_5678 + 1, then assert reset on the 4th RUN cycle. Required: IDLE next cycle, outputs 0, no done pulse. A fresh 2+2 afterwards returns 4.
